// File: rtl/seg7_display_arbiter_if.sv
// Requester/arbiter bundle for the shared seven-segment display.
// master: requester side; slave: the arbiter.
interface seg7_display_arbiter_if;
    logic [3:0]   req;
    logic [127:0] reqData;
    logic         freeze;
    logic [3:0]   grant;
    logic         ack;
    logic [1:0]   owner;
    logic [31:0]  displayData;
    logic         busy;

    modport master (
        output req, reqData, freeze,
        input  grant, ack, owner, displayData, busy
    );

    modport slave (
        input  req, reqData, freeze,
        output grant, ack, owner, displayData, busy
    );
endinterface

// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter time-sharing one 32-bit display word among four requesters,
// with a minimum dwell per grant and a freeze input that stretches the dwell.
module seg7_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter int unsigned CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input logic                    CLK,
    input logic                    RST_N,
    seg7_display_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rr_q, rr_d;
    logic [1:0]       owner_q, owner_d;
    logic [3:0]       grant_q, grant_d;
    logic             ack_q, ack_d;
    logic [31:0]      data_q, data_d;

    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic [1:0]       cand;

    // Scan from farthest to nearest so the candidate closest to rr_q wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_q;
        cand       = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_q + 2'(k);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        ack_d   = 1'b0;
        data_d  = data_q;

        case (state_q)
            StIdle: begin
                grant_d = '0;
                if (!bus.freeze && pick_valid) begin
                    state_d = StHold;
                    grant_d = 4'b0001 << pick_idx;
                    ack_d   = 1'b1;
                    owner_d = pick_idx;
                    data_d  = bus.reqData[{pick_idx, 5'b0} +: 32];
                    cnt_d   = CntLoad;
                    rr_d    = pick_idx + 2'd1;
                end
            end
            StHold: begin
                // A departed owner keeps its last word on display until the dwell ends.
                if (bus.req[owner_q]) begin
                    data_d = bus.reqData[{owner_q, 5'b0} +: 32];
                end
                if (!bus.freeze) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rr_q    <= '0;
            owner_q <= '0;
            grant_q <= '0;
            ack_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.ack         = ack_q;
    assign bus.owner       = owner_q;
    assign bus.displayData = data_q;
    assign bus.busy        = (state_q == StHold);

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with HOLD_CYCLES = 4.
module tb_seg7_display_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seg7_display_arbiter_if bus ();

    seg7_display_arbiter #(
        .HOLD_CYCLES (4)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called right after a granting edge; returns right after the idle-gap edge.
    task automatic run_grant(input logic [1:0] idx, input logic [31:0] d, input int len);
        logic [3:0] g;
        g = 4'b0001 << idx;
        chk("grant_start", 32'(bus.grant), 32'(g));
        chk("ack_start", 32'(bus.ack), 32'd1);
        chk("owner_start", 32'(bus.owner), 32'(idx));
        chk("data_start", bus.displayData, d);
        chk("busy_start", 32'(bus.busy), 32'd1);
        for (int k = 1; k < len; k++) begin
            tick();
            chk("grant_hold", 32'(bus.grant), 32'(g));
            chk("ack_hold", 32'(bus.ack), 32'd0);
        end
        tick();
        chk("gap_grant", 32'(bus.grant), 32'd0);
        chk("gap_busy", 32'(bus.busy), 32'd0);
        chk("gap_owner", 32'(bus.owner), 32'(idx));
        chk("gap_data", bus.displayData, d);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req = 4'hF;
        bus.freeze = 1'b0;
        bus.reqData = {32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111};

        // Reset held for three cycles with every source requesting
        tick(); tick(); tick();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_data", bus.displayData, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // First grant after release goes to source 0, then round-robin over 1011
        rst_n = 1'b1;
        tick();
        bus.req = 4'b1011;
        run_grant(2'd0, 32'h11111111, 4);
        tick();
        run_grant(2'd1, 32'h22222222, 4);
        tick();
        run_grant(2'd3, 32'h88888888, 4);
        tick();
        run_grant(2'd0, 32'h11111111, 4);

        // Tracking then freezing of displayData for source 2
        bus.req = 4'b0100;
        tick();
        chk("trk_grant", 32'(bus.grant), 32'h4);
        chk("trk_ack", 32'(bus.ack), 32'd1);
        chk("trk_data0", bus.displayData, 32'h44444444);
        bus.reqData[64 +: 32] = 32'hDEADBEEF;
        tick();
        chk("trk_follow", bus.displayData, 32'hDEADBEEF);
        bus.req = 4'b0000;
        tick();
        bus.reqData[64 +: 32] = 32'h12345678;
        tick();
        chk("trk_frozen", bus.displayData, 32'hDEADBEEF);
        chk("trk_grant_last", 32'(bus.grant), 32'h4);
        tick();
        chk("trk_end_grant", 32'(bus.grant), 32'd0);
        chk("trk_end_data", bus.displayData, 32'hDEADBEEF);

        // Freeze for three cycles mid-HOLD stretches the grant to seven cycles
        bus.req = 4'b0001;
        tick();
        chk("frz_grant", 32'(bus.grant), 32'h1);
        chk("frz_data", bus.displayData, 32'h11111111);
        tick();
        bus.freeze = 1'b1;
        tick(); tick(); tick();
        bus.freeze = 1'b0;
        chk("frz_held", 32'(bus.grant), 32'h1);
        tick(); tick();
        chk("frz_cycle7", 32'(bus.grant), 32'h1);
        chk("frz_busy7", 32'(bus.busy), 32'd1);
        tick();
        chk("frz_end", 32'(bus.grant), 32'd0);

        // Freeze in IDLE blocks new grants until it falls
        bus.freeze = 1'b1;
        bus.req = 4'b0010;
        tick();
        chk("frz_idle1", 32'(bus.grant), 32'd0);
        tick(); tick();
        chk("frz_idle3", 32'(bus.grant), 32'd0);
        chk("frz_idle_busy", 32'(bus.busy), 32'd0);
        bus.freeze = 1'b0;
        tick();

        // Lone requester: repeated grants to source 1 with a one-cycle gap
        run_grant(2'd1, 32'h22222222, 4);
        tick();
        run_grant(2'd1, 32'h22222222, 4);

        // Reset at dwell cycle 2 aborts the grant and rewinds the pointer
        tick();
        chk("mid_grant", 32'(bus.grant), 32'h2);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_grant", 32'(bus.grant), 32'd0);
        chk("mid_rst_data", bus.displayData, 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_owner", 32'(bus.owner), 32'd0);
        chk("mid_rst_ack", 32'(bus.ack), 32'd0);
        rst_n = 1'b1;
        bus.req = 4'hF;
        tick();
        chk("mid_rr_grant", 32'(bus.grant), 32'h1);
        chk("mid_rr_owner", 32'(bus.owner), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
